// File: rtl/uart_rx_oversample.sv
// 16x-oversampled UART receiver: start-bit validation, 3-sample majority vote, LSB-first data.
// Latency: done/err one clk after the mid-stop-bit deciding tick; no backpressure, consumer must take each strobe.
module uart_rx_oversample #(
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 done,
    output logic                 err,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CNT_PRE  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] CNT_POST = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [1:0]             smp_q, smp_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   maj;

    assign rx_s = sync_q[SYNC_STAGES-1];

    // The third vote is the live sample at the post-centre count.
    assign maj = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        smp_d   = smp_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (tick) begin
            if (state_q != IDLE && state_q != WAIT_HIGH) begin
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
                if (cnt_q == CNT_PRE) smp_d[0] = rx_s;
                if (cnt_q == CNT_MID) smp_d[1] = rx_s;
            end
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    if (cnt_q == CNT_POST && maj) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_POST) shreg_d[idx_q] = maj;
                    if (cnt_q == CNT_LAST) begin
                        if (idx_q == IDX_LAST) state_d = STOP;
                        else                   idx_d   = idx_q + 1'b1;
                    end
                end
                STOP: begin
                    // Leaving at mid-stop-bit leaves time to catch a back-to-back start edge.
                    if (cnt_q == CNT_POST) begin
                        cnt_d = '0;
                        if (maj) begin
                            data_d  = shreg_q;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            smp_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            smp_q   <= smp_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign data = data_q;
    assign done = done_q;
    assign err  = err_q;
    assign busy = (state_q != IDLE);

endmodule

// File: doc/uart_rx_oversample.md
Name: uart_rx_oversample

Overview:
- 16x-oversampled UART receiver sitting directly upstream of the tapeout UART wrapper's receive FIFO.
- Converts the asynchronous rx pin into 8-bit bytes, with start-bit validation and 3-sample majority voting.
- Emits a one-cycle done or err strobe per frame; the wrapper writes data into fifoRx on done && !err.

Parameters:
- OVERSAMPLE, 16: tick enables per bit period; must be an even integer >= 8.
- DATA_BITS, 8: data bits per frame, sent LSB first.
- SYNC_STAGES, 2: flops in the rx metastability synchronizer (>= 2).

Ports:
- clk  input  1  system clock.
- nReset  input  1  asynchronous, active-low reset.
- tick  input  1  oversample enable from the baud generator; one-clk pulse, OVERSAMPLE pulses per bit.
- rx  input  1  raw serial line; idle high.
- data  output  DATA_BITS  last good received byte.
- done  output  1  one-clk pulse: frame received with valid stop bit.
- err  output  1  one-clk pulse: framing error (stop bit sampled low).
- busy  output  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset (async, nReset low):
  - Synchronizer flops = 1; state = IDLE; counters = 0.
  - data = 0, done = 0, err = 0, busy = 0.
- rx passes through SYNC_STAGES flops to give rx_s. All decisions use rx_s, evaluated only in clk cycles where tick = 1.
- State and counters hold when tick = 0.
- Per-bit tick counter: width $clog2(OVERSAMPLE), counts 0..OVERSAMPLE-1, wraps to 0 and advances the bit.
- Samples are taken at counts C-1, C, C+1, where C = OVERSAMPLE/2. Bit value = majority of the 3 samples.
- States:
  - IDLE: a tick with rx_s = 0 goes to START with count = 0.
  - START: at count C+1, majority 1 = false start: return to IDLE, no strobe. Majority 0 = valid start: continue to count OVERSAMPLE-1, then go to DATA with bit index = 0.
  - DATA: majority shifted into bit [index] (LSB first). At count OVERSAMPLE-1: if index = DATA_BITS-1 go to STOP, else index++.
  - STOP: at count C+1, majority 1 = good stop: data <= shift register, done pulse, go to IDLE. Majority 0 = framing error: err pulse, data unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until a tick with rx_s = 1, then go to IDLE. A break condition produces exactly one err.
- Strobe timing:
  - done/err are registered and assert the clk cycle after the deciding tick, for exactly one cycle.
  - done and err are never high together.
  - data is updated in the same cycle done rises and is stable until the next done.
- Returning to IDLE at mid-stop-bit lets a back-to-back start edge, arriving ~C ticks later, be caught with no lost frame.
- Reset mid-frame aborts with no strobe; the receiver resynchronizes on the next falling edge seen in IDLE.

Test Plan:
- Tick every 4 clk, OVERSAMPLE = 16. Send 0xA5 (8N1) -> single done pulse, data = 0xA5, err = 0, busy falls with done.
- Hold rx low for 3 ticks, then high -> busy pulses, no done, no err, data unchanged (0xA5).
- Send 0x3C with stop bit forced 0, line held low for 20 more bit times, then high, then send 0x5A -> exactly one err, data stays 0xA5, then done with data = 0x5A.
- Send 0x00, with rx inverted for one tick at count C of bit 3 -> done, data = 0x00 (majority vote rejects the glitch).
- Send 0x01 then 0xFF back-to-back with no idle gap -> two done pulses, data = 0x01 then 0xFF, no err.
- Assert nReset mid-DATA of a frame -> all outputs 0 immediately; after release, send 0x7E -> done, data = 0x7E.
